range_counter: RTL and testbench

RANGE_COUNTER -- requirements
Module: range_counter

---
 rtl/range_counter_pkg.sv | 10 +
 rtl/range_counter_term.sv | 27 ++
 rtl/range_counter.sv | 83 ++++++++
 tb/tb_range_counter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/range_counter_pkg.sv
// Shared constants for the range counter: direction encodings and default bounds.
package range_counter_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int unsigned START_DEF_C = 3;
  localparam int unsigned END_DEF_C   = 15;

endpackage : range_counter_pkg

// File: rtl/range_counter_term.sv
// Terminal-value detector for the range counter.
// The down-direction compare and its ports exist only with RANGE_COUNTER_DOWN_EN defined.
module range_counter_term
  import range_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] out,
`ifdef RANGE_COUNTER_DOWN_EN
  input  logic [WIDTH-1:0] start_r,
  input  logic             dir,
`endif
  input  logic [WIDTH-1:0] end_r,
  output logic             at_term
);

  // Terminal when the count has reached the bound it is heading towards.
  always_comb begin
    at_term = (out >= end_r);
`ifdef RANGE_COUNTER_DOWN_EN
    if (dir == DIR_DOWN) begin
      at_term = (out <= start_r);
    end
`endif
  end

endmodule : range_counter_term

// File: rtl/range_counter.sv
// Bounded wrap-around counter with loadable start/end bounds and a wrap pulse.
// Optional down counting is enabled by defining RANGE_COUNTER_DOWN_EN.
module range_counter
  import range_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned START_DEF = START_DEF_C,
  parameter int unsigned END_DEF   = END_DEF_C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             ld_cfg,
  input  logic [WIDTH-1:0] cfg_start,
  input  logic [WIDTH-1:0] cfg_end,
`ifdef RANGE_COUNTER_DOWN_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] out,
  output logic             co,
  output logic             at_term
);

  logic [WIDTH-1:0] start_r;
  logic [WIDTH-1:0] end_r;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] wrap_val;

  // Terminal detection is shared between the at_term output and the wrap decision.
  range_counter_term #(
    .WIDTH (WIDTH)
  ) u_term (
    .out     (out),
`ifdef RANGE_COUNTER_DOWN_EN
    .start_r (start_r),
    .dir     (dir),
`endif
    .end_r   (end_r),
    .at_term (at_term)
  );

  // Non-terminal step and the value loaded on a wrap, per direction.
  always_comb begin
    step_val = out + WIDTH'(1);
    wrap_val = start_r;
`ifdef RANGE_COUNTER_DOWN_EN
    if (dir == DIR_DOWN) begin
      step_val = out - WIDTH'(1);
      wrap_val = end_r;
    end
`endif
  end

  // Bounds, count and wrap pulse; priority rst > ld_cfg > clr > en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_r <= WIDTH'(START_DEF);
      end_r   <= WIDTH'(END_DEF);
      out     <= WIDTH'(START_DEF);
      co      <= 1'b0;
    end else if (ld_cfg) begin
      start_r <= cfg_start;
      end_r   <= cfg_end;
      out     <= cfg_start;
      co      <= 1'b0;
    end else if (clr) begin
      out     <= start_r;
      co      <= 1'b0;
    end else if (en) begin
      if (at_term) begin
        out <= wrap_val;
        co  <= 1'b1;
      end else begin
        out <= step_val;
        co  <= 1'b0;
      end
    end else begin
      co <= 1'b0;
    end
  end

endmodule : range_counter

// File: tb/tb_range_counter.sv
// Directed self-checking bench for range_counter (WIDTH=4, default bounds 3..15).
module tb_range_counter;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             clr;
  logic             en;
  logic             ld_cfg;
  logic [WIDTH-1:0] cfg_start;
  logic [WIDTH-1:0] cfg_end;
`ifdef RANGE_COUNTER_DOWN_EN
  logic             dir;
`endif
  logic [WIDTH-1:0] out;
  logic             co;
  logic             at_term;

  int checks;
  int failures;

  range_counter #(
    .WIDTH     (WIDTH),
    .START_DEF (3),
    .END_DEF   (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .en        (en),
    .ld_cfg    (ld_cfg),
    .cfg_start (cfg_start),
    .cfg_end   (cfg_end),
`ifdef RANGE_COUNTER_DOWN_EN
    .dir       (dir),
`endif
    .out       (out),
    .co        (co),
    .at_term   (at_term)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int exp_out, input logic exp_co);
    chk({tag, ".out"}, 16'(out), 16'(exp_out));
    chk({tag, ".co"}, 16'(co), 16'(exp_co));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    clr       = 1'b0;
    en        = 1'b0;
    ld_cfg    = 1'b0;
    cfg_start = '0;
    cfg_end   = '0;
`ifdef RANGE_COUNTER_DOWN_EN
    dir       = 1'b0;
`endif
    #2;
    chk_state("reset", 3, 1'b0);
    chk("reset.at_term", 16'(at_term), 16'(0));
    tick();
    rst = 1'b0;

    // Full default range: 3 -> 15, then a single wrap pulse back to 3.
    en = 1'b1;
    for (int i = 4; i <= 15; i++) begin
      tick();
      chk_state($sformatf("run%0d", i), i, 1'b0);
    end
    chk("run15.at_term", 16'(at_term), 16'(1));
    tick();
    chk_state("wrap_default", 3, 1'b1);
    chk("wrap_default.at_term", 16'(at_term), 16'(0));
    tick();
    chk_state("after_wrap", 4, 1'b0);

    // Load bounds 2..5 with en low, then count 3,4,5,2.
    en = 1'b0; ld_cfg = 1'b1; cfg_start = 4'd2; cfg_end = 4'd5;
    tick();
    ld_cfg = 1'b0;
    chk_state("ld25", 2, 1'b0);
    en = 1'b1;
    tick(); chk_state("b25_3", 3, 1'b0);
    tick(); chk_state("b25_4", 4, 1'b0);
    tick(); chk_state("b25_5", 5, 1'b0);
    chk("b25_5.at_term", 16'(at_term), 16'(1));
    tick(); chk_state("b25_wrap", 2, 1'b1);
    en = 1'b0;
    tick(); chk_state("b25_hold", 2, 1'b0);

    // Load wins over en in the same cycle; clr at 9 restarts at start_r.
    en = 1'b1; ld_cfg = 1'b1; cfg_start = 4'd6; cfg_end = 4'd12;
    tick();
    ld_cfg = 1'b0;
    chk_state("ld_en", 6, 1'b0);
    tick(); chk_state("c7", 7, 1'b0);
    tick(); chk_state("c8", 8, 1'b0);
    tick(); chk_state("c9", 9, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_state("clr", 6, 1'b0);

    // Async reset mid-count at 9 takes effect between edges.
    tick(); tick(); tick();
    chk_state("pre_rst", 9, 1'b0);
    en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_state("async_rst", 3, 1'b0);
    #1;
    rst = 1'b0;
    en  = 1'b1;
    tick();
    chk_state("resume", 4, 1'b0);

    // Reset restored the default end bound: 4..15 then wrap.
    for (int i = 5; i <= 15; i++) tick();
    chk_state("rst_end15", 15, 1'b0);
    tick();
    chk_state("rst_wrap", 3, 1'b1);

    // Inverted bounds: terminal on every enabled cycle.
    en = 1'b0; ld_cfg = 1'b1; cfg_start = 4'd9; cfg_end = 4'd4;
    tick();
    ld_cfg = 1'b0;
    chk_state("inv_ld", 9, 1'b0);
    chk("inv_ld.at_term", 16'(at_term), 16'(1));
    en = 1'b1;
    tick(); chk_state("inv_1", 9, 1'b1);
    tick(); chk_state("inv_2", 9, 1'b1);
    en = 1'b0;
    tick(); chk_state("inv_off", 9, 1'b0);

`ifdef RANGE_COUNTER_DOWN_EN
    // Down count from 4 with bounds 3..15: 4 -> 3 -> 15 (wrap).
    ld_cfg = 1'b1; cfg_start = 4'd3; cfg_end = 4'd15;
    tick();
    ld_cfg = 1'b0;
    en = 1'b1;
    tick();
    chk_state("dn_pre", 4, 1'b0);
    dir = 1'b1;
    #1;
    chk("dn_pre.at_term", 16'(at_term), 16'(0));
    tick(); chk_state("dn_3", 3, 1'b0);
    chk("dn_3.at_term", 16'(at_term), 16'(1));
    tick(); chk_state("dn_wrap", 15, 1'b1);
    tick(); chk_state("dn_14", 14, 1'b0);
    en = 1'b0; dir = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_range_counter
